// File: rtl/jt12_frame_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jt12_frame_mixer                                                           |
// | Sums per-channel L/R results over one FM frame into a saturated stereo     |
// | sample with per-channel mute, fixed gain shift and a one-cycle strobe.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module jt12_frame_mixer #(
  parameter int GAIN_SH = 0,
  parameter int NCH     = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic               zero,
  input  logic               ch_valid,
  input  logic signed [15:0] left_in,
  input  logic signed [15:0] right_in,
  input  logic        [5:0]  mute,
  output logic signed [15:0] left,
  output logic signed [15:0] right,
  output logic               sample,
  output logic        [1:0]  clip,
  output logic               frame_err
);

  localparam logic        [2:0]  c_nch = 3'(NCH);
  localparam logic signed [20:0] c_max = 21'sd32767;
  localparam logic signed [20:0] c_min = -21'sd32768;

  logic signed [18:0] r_acc_l, r_acc_r;
  logic        [2:0]  r_idx;
  logic               r_err;

  logic        [7:0]  w_mute_ext;
  logic               w_drop;
  logic               w_over;
  logic        [2:0]  w_idx_inc;
  logic        [2:0]  w_cnt;
  logic signed [18:0] w_term_l, w_term_r;
  logic signed [18:0] w_sum_l, w_sum_r;
  logic signed [20:0] w_sh_l, w_sh_r;
  logic        [16:0] w_sat_l, w_sat_r;

  // Result is {clipped, value}.
  function automatic logic [16:0] sat16(input logic signed [20:0] v);
    if (v > c_max)      return {1'b1, 16'h7fff};
    else if (v < c_min) return {1'b1, 16'h8000};
    else                return {1'b0, v[15:0]};
  endfunction

  always_comb begin
    // Slots 6 and 7 read as muted so surplus channels never reach the sum.
    w_mute_ext = {2'b11, mute};
    w_drop     = w_mute_ext[r_idx];
    w_over     = (r_idx >= c_nch);
    w_idx_inc  = (r_idx == 3'd7) ? 3'd7 : r_idx + 3'd1;
    w_cnt      = ch_valid ? w_idx_inc : r_idx;
    w_term_l   = (ch_valid && !w_drop) ? {{3{left_in[15]}},  left_in}  : 19'sd0;
    w_term_r   = (ch_valid && !w_drop) ? {{3{right_in[15]}}, right_in} : 19'sd0;
    w_sum_l    = r_acc_l + w_term_l;
    w_sum_r    = r_acc_r + w_term_r;
    w_sh_l     = $signed({{2{w_sum_l[18]}}, w_sum_l}) <<< GAIN_SH;
    w_sh_r     = $signed({{2{w_sum_r[18]}}, w_sum_r}) <<< GAIN_SH;
    w_sat_l    = sat16(w_sh_l);
    w_sat_r    = sat16(w_sh_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_l   <= '0;
      r_acc_r   <= '0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      left      <= '0;
      right     <= '0;
      sample    <= 1'b0;
      clip      <= '0;
      frame_err <= 1'b0;
    end else begin
      // Strobe clears on every edge, enabled or not.
      sample <= clk_en & zero;
      if (clk_en) begin
        if (zero) begin
          left      <= w_sat_l[15:0];
          right     <= w_sat_r[15:0];
          clip      <= {w_sat_l[16], w_sat_r[16]};
          frame_err <= r_err | (ch_valid & w_over) | (w_cnt != c_nch);
          r_acc_l   <= '0;
          r_acc_r   <= '0;
          r_idx     <= '0;
          r_err     <= 1'b0;
        end else if (ch_valid) begin
          r_acc_l <= w_sum_l;
          r_acc_r <= w_sum_r;
          r_idx   <= w_idx_inc;
          if (w_over) r_err <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
